// File: rtl/hough_pkg.sv
// hough_pkg: shared types, defaults and peak-validity rule for the Hough lane pipeline.
// Optional feature macro: PEAK_THRESH_EN (peak valid only when votes >= THRESHOLD).
package hough_pkg;

    localparam int DEF_THETAS = 180;
    localparam int DEF_RHOS   = 900;
    localparam int ACCUM_BITS = 8;
    localparam int RHO_BITS   = 10;
    localparam int THETA_BITS = 8;
    localparam int THRESHOLD  = 20;

    typedef struct packed {
        logic                  valid;
        logic [RHO_BITS-1:0]   rho;
        logic [THETA_BITS-1:0] theta;
        logic [ACCUM_BITS-1:0] votes;
    } peak_t;

    typedef enum logic [1:0] {SCAN, EMIT_L, EMIT_R} state_t;

    // A peak is reportable when it clears the threshold, or is simply nonzero by default
    function automatic logic peak_valid(input logic [ACCUM_BITS-1:0] votes);
`ifdef PEAK_THRESH_EN
        return votes >= ACCUM_BITS'(THRESHOLD);
`else
        return votes != '0;
`endif
    endfunction

endpackage

// File: rtl/hough_peak_finder_if.sv
// hough_peak_finder_if: input-FIFO read side, output-FIFO write side and frame pulse.
interface hough_peak_finder_if;
    import hough_pkg::*;

    logic                  in_empty;
    logic [ACCUM_BITS-1:0] in_dout;
    logic                  in_rd_en;
    logic                  out_full;
    logic                  out_wr_en;
    peak_t                 out_din;
    logic                  frame_done;

    modport master (
        input  in_empty, in_dout, out_full,
        output in_rd_en, out_wr_en, out_din, frame_done
    );

    modport slave (
        output in_empty, in_dout, out_full,
        input  in_rd_en, out_wr_en, out_din, frame_done
    );

endinterface

// File: rtl/hough_peak_tracker.sv
// hough_peak_tracker: holds the strongest bin seen so far in one theta half.
module hough_peak_tracker
    import hough_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  upd,
    input  logic [RHO_BITS-1:0]   rho,
    input  logic [THETA_BITS-1:0] theta,
    input  logic [ACCUM_BITS-1:0] votes,
    output peak_t                 best
);

    logic [RHO_BITS-1:0]   rho_q, rho_d;
    logic [THETA_BITS-1:0] theta_q, theta_d;
    logic [ACCUM_BITS-1:0] votes_q, votes_d;
    logic                  take;

    // Strictly larger wins so the earliest bin keeps a tie; clear starts a new frame
    always_comb begin
        take    = upd && (votes > votes_q);
        rho_d   = clear ? '0 : take ? rho   : rho_q;
        theta_d = clear ? '0 : take ? theta : theta_q;
        votes_d = clear ? '0 : take ? votes : votes_q;
    end

    // Best-record register
    always_ff @(posedge clock) begin
        if (reset) begin
            rho_q   <= '0;
            theta_q <= '0;
            votes_q <= '0;
        end else begin
            rho_q   <= rho_d;
            theta_q <= theta_d;
            votes_q <= votes_d;
        end
    end

    // Sub-threshold peaks stay tracked but are reported as an all-zero invalid record
    always_comb begin
        best = peak_valid(votes_q) ? peak_t'{valid: 1'b1, rho: rho_q, theta: theta_q, votes: votes_q} : '0;
    end

endmodule

// File: rtl/hough_peak_finder.sv
// hough_peak_finder: scans one accumulator frame, emits left then right lane peaks.
// Optional feature macro: PEAK_THRESH_EN (applied through hough_pkg::peak_valid).
module hough_peak_finder
    import hough_pkg::*;
#(
    parameter int THETAS = DEF_THETAS,
    parameter int RHOS   = DEF_RHOS
)
(
    input logic                 clock,
    input logic                 reset,
    hough_peak_finder_if.master bus
);

    state_t                state_q, state_d;
    logic [THETA_BITS-1:0] theta_q, theta_d;
    logic [RHO_BITS-1:0]   rho_q, rho_d;
    logic                  pop, push, last_theta, last_word, left_sel, clear;
    peak_t                 left_pk, right_pk;

    // Handshakes, bin counters and frame sequencing
    always_comb begin
        pop        = !reset && state_q == SCAN && !bus.in_empty;
        push       = !reset && state_q != SCAN && !bus.out_full;
        last_theta = theta_q == THETA_BITS'(THETAS - 1);
        last_word  = last_theta && rho_q == RHO_BITS'(RHOS - 1);
        left_sel   = theta_q < THETA_BITS'(THETAS / 2);
        clear      = push && state_q == EMIT_R;
        theta_d    = pop ? (last_theta ? '0 : theta_q + 1'b1) : theta_q;
        rho_d      = (pop && last_theta) ? (last_word ? '0 : rho_q + 1'b1) : rho_q;
        state_d    = (pop && last_word) ? EMIT_L :
                     !push              ? state_q :
                     (state_q == EMIT_L) ? EMIT_R : SCAN;
    end

    // State and counter registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= SCAN;
            theta_q <= '0;
            rho_q   <= '0;
        end else begin
            state_q <= state_d;
            theta_q <= theta_d;
            rho_q   <= rho_d;
        end
    end

    hough_peak_tracker u_left (
        .clock (clock),
        .reset (reset),
        .clear (clear),
        .upd   (pop && left_sel),
        .rho   (rho_q),
        .theta (theta_q),
        .votes (bus.in_dout),
        .best  (left_pk)
    );

    hough_peak_tracker u_right (
        .clock (clock),
        .reset (reset),
        .clear (clear),
        .upd   (pop && !left_sel),
        .rho   (rho_q),
        .theta (theta_q),
        .votes (bus.in_dout),
        .best  (right_pk)
    );

    // FIFO strobes and output record mux; everything is held at 0 while in reset
    always_comb begin
        bus.in_rd_en   = pop;
        bus.out_wr_en  = push;
        bus.frame_done = clear;
        bus.out_din    = reset              ? '0 :
                         state_q == EMIT_L ? left_pk :
                         state_q == EMIT_R ? right_pk : '0;
    end

endmodule

// File: tb/tb_hough_peak_finder.sv
// tb_hough_peak_finder: directed frames on a 3x4 accumulator checked against a max/first-index model.
module tb_hough_peak_finder;
    import hough_pkg::*;

    localparam int TH = 4;
    localparam int RH = 3;
    localparam int N  = TH * RH;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    hough_peak_finder_if bus ();

    hough_peak_finder #(.THETAS(TH), .RHOS(RH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int compared   = 0;
    int mismatched = 0;
    int done_cnt   = 0;
    bit expect_out = 1'b0;
    logic [ACCUM_BITS-1:0] frm [N];
    peak_t exp_q [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Peak of one half: largest vote count, earliest bin holding it, then the validity rule
    function automatic peak_t model(input bit right);
        int mx = 0;
        int at = 0;
        bit v;
        peak_t p = '0;
        for (int i = 0; i < N; i++)
            if (((i % TH) >= TH / 2) == right && int'(frm[i]) > mx) mx = int'(frm[i]);
        for (int i = N - 1; i >= 0; i--)
            if (((i % TH) >= TH / 2) == right && int'(frm[i]) == mx) at = i;
`ifdef PEAK_THRESH_EN
        v = mx >= 20;
`else
        v = mx > 0;
`endif
        if (v) p = '{1'b1, RHO_BITS'(at / TH), THETA_BITS'(at % TH), ACCUM_BITS'(mx)};
        return p;
    endfunction

    function automatic peak_t pk(input int r, input int t, input int v);
        return '{1'b1, RHO_BITS'(r), THETA_BITS'(t), ACCUM_BITS'(v)};
    endfunction

    task automatic load2(input int i1, input int v1, input int i2, input int v2);
        for (int i = 0; i < N; i++) frm[i] = '0;
        frm[i1] = ACCUM_BITS'(v1);
        frm[i2] = ACCUM_BITS'(v2);
    endtask

    // Per-cycle output checker
    always @(negedge clock) begin
        if (reset) begin
            chk("rst_rd_en", bus.in_rd_en, 0);
            chk("rst_wr_en", bus.out_wr_en, 0);
            chk("rst_din", bus.out_din, 0);
            chk("rst_done", bus.frame_done, 0);
        end else begin
            chk("rd_when_empty", bus.in_rd_en && bus.in_empty, 0);
            if (expect_out && exp_q.size() > 0) begin
                chk("out_din", bus.out_din, exp_q[0]);
                chk("out_wr_en", bus.out_wr_en, !bus.out_full);
                chk("rd_during_emit", bus.in_rd_en, 0);
                chk("frame_done", bus.frame_done, !bus.out_full && exp_q.size() == 1);
                if (bus.out_wr_en) void'(exp_q.pop_front());
            end else begin
                chk("idle_wr_en", bus.out_wr_en, 0);
                chk("idle_done", bus.frame_done, 0);
            end
        end
        if (bus.frame_done) done_cnt++;
    end

    // Feed frm through a FWFT FIFO model and wait for both records
    task automatic run_frame(input bit stall, input int full_hold);
        int idx = 0;
        int cyc = 0;
        int held = 0;
        int d0 = done_cnt;
        bit pop;
        exp_q = {model(1'b0), model(1'b1)};
        expect_out = 1'b0;
        while (cyc < 500) begin
            bus.in_empty = (idx >= N) || (stall && (cyc % 2) == 1);
            bus.in_dout  = bus.in_empty ? 8'hEE : frm[idx];
            bus.out_full = (idx >= N) && (held < full_hold);
            if (bus.out_full) held++;
            @(negedge clock);
            pop = bus.in_rd_en;
            @(posedge clock);
            #1;
            if (pop) idx++;
            cyc++;
            if (idx == N) expect_out = 1'b1;
            if (expect_out && exp_q.size() == 0) break;
        end
        chk("frame_timeout", cyc < 500, 1);
        chk("pops", idx, N);
        chk("done_pulses", done_cnt - d0, 1);
        expect_out = 1'b0;
        bus.in_empty = 1'b1;
        bus.out_full = 1'b0;
        repeat (2) @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.in_empty = 1'b0;
        bus.in_dout  = 8'hEE;
        bus.out_full = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        bus.in_empty = 1'b1;
        @(posedge clock);
        #1;

        // 1: all-zero frame
        for (int i = 0; i < N; i++) frm[i] = '0;
        chk("pin_zero_l", model(1'b0), 0);
        chk("pin_zero_r", model(1'b1), 0);
        run_frame(1'b0, 0);

        // 2: single peak in each half
        load2(4, 9, 11, 5);
        chk("pin_t2_l", model(1'b0), pk(1, 0, 9));
        chk("pin_t2_r", model(1'b1), pk(2, 3, 5));
        run_frame(1'b0, 0);

        // 3: tie on the left, empty right half
        load2(1, 7, 8, 7);
        chk("pin_t3_l", model(1'b0), pk(0, 1, 7));
        chk("pin_t3_r", model(1'b1), 0);
        run_frame(1'b0, 0);

        // 4: frame 2 again with input bubbles and 10 cycles of output back-pressure
        load2(4, 9, 11, 5);
        run_frame(1'b1, 10);

        // 5: threshold boundary, 19 left and 20 right
        load2(5, 19, 10, 20);
`ifdef PEAK_THRESH_EN
        chk("pin_t5_l", model(1'b0), 0);
`else
        chk("pin_t5_l", model(1'b0), pk(1, 1, 19));
`endif
        chk("pin_t5_r", model(1'b1), pk(2, 2, 20));
        run_frame(1'b0, 0);

        // mixed values with full-scale votes and repeated maxima
        frm = '{8'd3, 8'd8, 8'd128, 8'd8, 8'd1, 8'd4, 8'd6, 8'd255, 8'd8, 8'd0, 8'd6, 8'd5};
        chk("pin_mix_l", model(1'b0), pk(0, 1, 8));
        chk("pin_mix_r", model(1'b1), pk(1, 3, 255));
        run_frame(1'b1, 3);

        // 6: reset after 6 pops of a strong frame, then a fresh frame
        for (int i = 0; i < N; i++) frm[i] = 8'd200;
        begin
            int idx = 0;
            int cyc = 0;
            bit pop;
            while (idx < 6 && cyc < 100) begin
                bus.in_empty = 1'b0;
                bus.in_dout  = frm[idx];
                @(negedge clock);
                pop = bus.in_rd_en;
                @(posedge clock);
                #1;
                if (pop) idx++;
                cyc++;
            end
            chk("partial_pops", idx, 6);
        end
        bus.in_empty = 1'b0;
        bus.in_dout  = 8'hEE;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        bus.in_empty = 1'b1;
        @(posedge clock);
        #1;
        load2(4, 9, 11, 5);
        run_frame(1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
